// File: rtl/mem_bus_arbiter_pkg.sv
// Shared types and default widths for the I/D memory bus arbiter.
// Imported by the arbiter top and referenced by its bus interface.
package mem_arb_pkg;

  localparam int ADDR_W_DEF  = 32;
  localparam int DATA_W_DEF  = 32;
  localparam int TIMEOUT_DEF = 255;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    DONE  = 2'd2
  } arb_state_e;

  typedef enum logic {
    OWN_I = 1'b0,
    OWN_D = 1'b1
  } owner_e;

  // Grant vector bit 1 is the data side, bit 0 the instruction side.
  function automatic owner_e owner_of(input logic [1:0] gnt);
    if (gnt[1]) begin
      return OWN_D;
    end else begin
      return OWN_I;
    end
  endfunction

endpackage

// File: rtl/mem_bus_arbiter_if.sv
// CPU-side (instruction and data) and memory-side signals of the arbiter.
// The arbiter takes the slave view; the CPU/memory environment the master view.
interface mem_bus_arbiter_if #(
  parameter int ADDR_W = mem_arb_pkg::ADDR_W_DEF,
  parameter int DATA_W = mem_arb_pkg::DATA_W_DEF
);

  logic              i_read;
  logic [ADDR_W-1:0] i_address;
  logic [DATA_W-1:0] i_readdata;
  logic              i_busywait;

  logic              d_read;
  logic              d_write;
  logic [ADDR_W-1:0] d_address;
  logic [DATA_W-1:0] d_writedata;
  logic [DATA_W-1:0] d_readdata;
  logic              d_busywait;

  logic              mem_read;
  logic              mem_write;
  logic [ADDR_W-1:0] mem_address;
  logic [DATA_W-1:0] mem_writedata;
  logic [DATA_W-1:0] mem_readdata;
  logic              mem_busywait;

  modport slave (
    input  i_read, i_address, d_read, d_write, d_address, d_writedata,
    input  mem_readdata, mem_busywait,
    output i_readdata, i_busywait, d_readdata, d_busywait,
    output mem_read, mem_write, mem_address, mem_writedata
  );

  modport master (
    output i_read, i_address, d_read, d_write, d_address, d_writedata,
    output mem_readdata, mem_busywait,
    input  i_readdata, i_busywait, d_readdata, d_busywait,
    input  mem_read, mem_write, mem_address, mem_writedata
  );

endinterface

// File: rtl/mem_bus_arbiter_rr2.sv
// Two-way round-robin arbiter: a tie goes to the side not served last.
// The pointer only moves when upd marks which side has just been served.
module arb_rr2 (
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] req,
  input  logic [1:0] upd,
  output logic [1:0] gnt
);

  // 0: instruction side served last, 1: data side served last
  logic ptr_r;

  // Last-served pointer; resets to the instruction side so data wins the first tie.
  always_ff @(posedge clk) begin
    if (reset) begin
      ptr_r <= 1'b0;
    end else if (upd[1]) begin
      ptr_r <= 1'b1;
    end else if (upd[0]) begin
      ptr_r <= 1'b0;
    end else begin
      ptr_r <= ptr_r;
    end
  end

  // Grant decode: a lone requester wins, a tie goes against the pointer.
  always_comb begin
    gnt = 2'b00;
    if (req == 2'b11) begin
      if (ptr_r) begin
        gnt = 2'b01;
      end else begin
        gnt = 2'b10;
      end
    end else begin
      gnt = req;
    end
  end

endmodule

// File: rtl/mem_bus_arbiter.sv
// Shares one memory port between instruction reads and data reads/writes.
// Serialises accesses through IDLE -> ISSUE -> DONE and flags a stuck memory.
module mem_bus_arbiter import mem_arb_pkg::*; #(
  parameter int ADDR_W  = ADDR_W_DEF,
  parameter int DATA_W  = DATA_W_DEF,
  parameter int TIMEOUT = TIMEOUT_DEF
) (
  input  logic                   clk,
  input  logic                   reset,
  mem_bus_arbiter_if.slave       bus,
  output logic                   err
);

  localparam int              CNT_W    = $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(TIMEOUT);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  arb_state_e        state_r;
  arb_state_e        state_next_s;
  owner_e            owner_r;
  logic [CNT_W-1:0]  wdog_cnt_r;
  logic              err_r;
  logic              mem_read_r;
  logic              mem_write_r;
  logic [ADDR_W-1:0] mem_address_r;
  logic [DATA_W-1:0] mem_writedata_r;
  logic [DATA_W-1:0] i_readdata_r;
  logic [DATA_W-1:0] d_readdata_r;

  logic              req_i_s;
  logic              req_d_s;
  logic [1:0]        gnt_s;
  logic [1:0]        upd_s;
  logic              mem_ack_s;

  assign req_i_s = bus.i_read;
  assign req_d_s = bus.d_read | bus.d_write;

  // The watchdog count is non-zero from the second ISSUE cycle on (it saturates, never wraps),
  // so it doubles as the "ignore MEM_BUSYWAIT in the first cycle" qualifier.
  assign mem_ack_s = (state_r == ISSUE) && (wdog_cnt_r != '0) && !bus.mem_busywait;

  arb_rr2 u_rr (
    .clk   (clk),
    .reset (reset),
    .req   ({req_d_s, req_i_s}),
    .upd   (upd_s),
    .gnt   (gnt_s)
  );

  // FSM state register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_next_s;
    end
  end

  // Next-state decode and round-robin pointer update on completion.
  always_comb begin
    state_next_s = state_r;
    upd_s        = 2'b00;
    case (state_r)
      IDLE: begin
        if (gnt_s != 2'b00) begin
          state_next_s = ISSUE;
        end else begin
          state_next_s = IDLE;
        end
      end
      ISSUE: begin
        if (mem_ack_s) begin
          state_next_s = DONE;
        end else begin
          state_next_s = ISSUE;
        end
      end
      DONE: begin
        state_next_s = IDLE;
        if (owner_r == OWN_D) begin
          upd_s = 2'b10;
        end else begin
          upd_s = 2'b01;
        end
      end
      default: begin
        state_next_s = IDLE;
      end
    endcase
  end

  // Command launch on grant, read-data capture on memory acknowledge.
  always_ff @(posedge clk) begin
    if (reset) begin
      owner_r         <= OWN_I;
      mem_read_r      <= 1'b0;
      mem_write_r     <= 1'b0;
      mem_address_r   <= '0;
      mem_writedata_r <= '0;
      i_readdata_r    <= '0;
      d_readdata_r    <= '0;
    end else begin
      case (state_r)
        IDLE: begin
          if (gnt_s != 2'b00) begin
            owner_r <= owner_of(gnt_s);
            if (gnt_s[1]) begin
              // read+write together is treated as a write
              mem_read_r      <= ~bus.d_write;
              mem_write_r     <= bus.d_write;
              mem_address_r   <= bus.d_address;
              mem_writedata_r <= bus.d_writedata;
            end else begin
              mem_read_r      <= 1'b1;
              mem_write_r     <= 1'b0;
              mem_address_r   <= bus.i_address;
              mem_writedata_r <= '0;
            end
          end
        end
        ISSUE: begin
          if (mem_ack_s) begin
            mem_read_r  <= 1'b0;
            mem_write_r <= 1'b0;
            // a requester that walked away does not get its result
            if (mem_read_r && (owner_r == OWN_I) && bus.i_read) begin
              i_readdata_r <= bus.mem_readdata;
            end
            if (mem_read_r && (owner_r == OWN_D) && bus.d_read) begin
              d_readdata_r <= bus.mem_readdata;
            end
          end
        end
        default: begin
        end
      endcase
    end
  end

  // Watchdog: counts ISSUE cycles, sets a sticky error once TIMEOUT is reached.
  always_ff @(posedge clk) begin
    if (reset) begin
      wdog_cnt_r <= '0;
      err_r      <= 1'b0;
    end else if (state_r == ISSUE) begin
      if (state_next_s != ISSUE) begin
        wdog_cnt_r <= '0;
      end else if (wdog_cnt_r != CNT_MAX) begin
        wdog_cnt_r <= wdog_cnt_r + CNT_W'(1);
      end
      if (wdog_cnt_r == CNT_LAST) begin
        err_r <= 1'b1;
      end
    end else begin
      wdog_cnt_r <= '0;
    end
  end

  assign bus.mem_read      = mem_read_r;
  assign bus.mem_write     = mem_write_r;
  assign bus.mem_address   = mem_address_r;
  assign bus.mem_writedata = mem_writedata_r;
  assign bus.i_readdata    = i_readdata_r;
  assign bus.d_readdata    = d_readdata_r;
  assign bus.i_busywait    = req_i_s & ~((state_r == DONE) && (owner_r == OWN_I));
  assign bus.d_busywait    = req_d_s & ~((state_r == DONE) && (owner_r == OWN_D));
  assign err               = err_r;

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Random I/D request traffic against a cycle-timeline reference model of the arbiter.
// Includes random mid-transaction resets, abandoned requests and a stuck-memory watchdog episode.
module tb_mem_bus_arbiter;

  localparam int AW   = 32;
  localparam int DW   = 32;
  localparam int TMO  = 8;
  localparam int NCYC = 2400;

  logic clk = 1'b0;
  logic reset;
  logic err;

  mem_bus_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

  mem_bus_arbiter #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT(TMO)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus),
    .err   (err)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  // memory contents, addresses drawn from a 16-word pool at 0x100
  logic [31:0] memarr [0:15];

  // reference model: one transaction timeline (grant cycle t0, w memory wait cycles)
  bit          act = 1'b0;
  int          t0 = 0;
  int          w = 0;
  bit          own_d = 1'b0;
  bit          is_wr = 1'b0;
  logic [31:0] t_addr = 32'h0;
  logic [31:0] t_wdata = 32'h0;
  bit          last_d = 1'b0;
  logic [31:0] exp_ird = 32'h0;
  logic [31:0] exp_drd = 32'h0;
  bit          exp_err = 1'b0;
  int          err_at = -1;
  bit          issuing = 1'b0;
  bit          done = 1'b0;

  // requester agents
  bit          i_req = 1'b0;
  logic [31:0] i_addr = 32'h0;
  bit          d_rd = 1'b0;
  bit          d_wr = 1'b0;
  logic [31:0] d_addr = 32'h0;
  logic [31:0] d_wdata = 32'h0;
  bit          i_hold = 1'b0;
  bit          d_hold = 1'b0;

  int          force_w = -1;
  bit          stuck_mode = 1'b0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s cyc=%0d got=%h exp=%h", tag, cyc, got, exp);
    end
  endtask

  function automatic logic [31:0] pool_addr();
    logic [3:0] idx;
    idx = 4'($urandom_range(0, 15));
    return 32'h0000_0100 + {26'h0, idx, 2'b00};
  endfunction

  task automatic run_checks();
    check_val("mem_read", 32'(bus.mem_read), 32'(issuing && !is_wr));
    check_val("mem_write", 32'(bus.mem_write), 32'(issuing && is_wr));
    if (issuing) begin
      check_val("mem_address", bus.mem_address, t_addr);
      if (is_wr) begin
        check_val("mem_writedata", bus.mem_writedata, t_wdata);
      end
    end
    check_val("i_busywait", 32'(bus.i_busywait), 32'(i_req && !(done && !own_d)));
    check_val("d_busywait", 32'(bus.d_busywait), 32'((d_rd || d_wr) && !(done && own_d)));
    check_val("i_readdata", bus.i_readdata, exp_ird);
    check_val("d_readdata", bus.d_readdata, exp_drd);
    check_val("err", 32'(err), 32'(exp_err));
  endtask

  task automatic new_i();
    i_req  = 1'b1;
    i_addr = pool_addr();
  endtask

  task automatic new_d();
    int kind;
    kind    = $urandom_range(0, 2);
    d_rd    = (kind != 1);
    d_wr    = (kind != 0);
    d_addr  = pool_addr();
    d_wdata = $urandom();
  endtask

  task automatic drive_stim();
    if (!act) begin
      i_hold = 1'b0;
      d_hold = 1'b0;
    end
    reset = (cyc < 3);
    if (cyc >= 3 && !stuck_mode && issuing && $urandom_range(0, 60) == 0) begin
      reset = 1'b1;
    end
    if (stuck_mode && act && w == 40 && cyc == t0 + TMO + 4) begin
      reset      = 1'b1;
      stuck_mode = 1'b0;
    end
    if (cyc == 2000) begin
      stuck_mode = 1'b1;
      force_w    = 40;
    end

    if (i_req) begin
      if (done && !own_d) begin
        if ($urandom_range(0, 1) == 1) new_i();
        else i_req = 1'b0;
      end else if (issuing && !own_d && $urandom_range(0, 19) == 0) begin
        i_req  = 1'b0;
        i_hold = 1'b1;
      end
    end else if (!i_hold && $urandom_range(0, 2) == 0) begin
      new_i();
    end

    if (d_rd || d_wr) begin
      if (done && own_d) begin
        if ($urandom_range(0, 1) == 1) new_d();
        else begin
          d_rd = 1'b0;
          d_wr = 1'b0;
        end
      end else if (issuing && own_d && $urandom_range(0, 19) == 0) begin
        d_rd   = 1'b0;
        d_wr   = 1'b0;
        d_hold = 1'b1;
      end
    end else if (!d_hold && $urandom_range(0, 2) == 0) begin
      new_d();
    end

    bus.i_read      = i_req;
    bus.i_address   = i_addr;
    bus.d_read      = d_rd;
    bus.d_write     = d_wr;
    bus.d_address   = d_addr;
    bus.d_writedata = d_wdata;
  endtask

  // Advance the reference model across the coming clock edge.
  task automatic model_step();
    if (reset) begin
      act     = 1'b0;
      last_d  = 1'b0;
      exp_ird = 32'h0;
      exp_drd = 32'h0;
      exp_err = 1'b0;
      err_at  = -1;
    end else if (act) begin
      if (cyc == t0 + w + 2) begin
        if (is_wr) begin
          memarr[t_addr[5:2]] = t_wdata;
        end else if (own_d && d_rd) begin
          exp_drd = memarr[t_addr[5:2]];
        end else if (!own_d && i_req) begin
          exp_ird = memarr[t_addr[5:2]];
        end
      end
      if (cyc == t0 + w + 3) begin
        act = 1'b0;
      end
    end else if (i_req || d_rd || d_wr) begin
      own_d  = (d_rd || d_wr) && (!i_req || !last_d);
      last_d = own_d;
      act    = 1'b1;
      t0     = cyc;
      if (force_w >= 0) begin
        w       = force_w;
        force_w = -1;
      end else begin
        w = $urandom_range(0, 4);
      end
      if (own_d) begin
        is_wr   = d_wr;
        t_addr  = d_addr;
        t_wdata = d_wdata;
      end else begin
        is_wr  = 1'b0;
        t_addr = i_addr;
      end
      if (w + 2 >= TMO) begin
        err_at = cyc + TMO + 1;
      end
    end
  endtask

  task automatic drive_mem();
    if (act && cyc >= t0 + 1 && cyc <= t0 + w + 2) begin
      bus.mem_busywait = (cyc >= t0 + 2) && (cyc <= t0 + w + 1);
      if (cyc == t0 + w + 2) bus.mem_readdata = memarr[t_addr[5:2]];
      else bus.mem_readdata = $urandom();
    end else begin
      bus.mem_busywait = 1'($urandom_range(0, 1));
      bus.mem_readdata = $urandom();
    end
  endtask

  initial begin
    reset            = 1'b1;
    bus.i_read       = 1'b0;
    bus.i_address    = 32'h0;
    bus.d_read       = 1'b0;
    bus.d_write      = 1'b0;
    bus.d_address    = 32'h0;
    bus.d_writedata  = 32'h0;
    bus.mem_busywait = 1'b0;
    bus.mem_readdata = 32'h0;
    for (int k = 0; k < 16; k++) begin
      memarr[k] = $urandom();
    end
    for (int c = 0; c < NCYC; c++) begin
      @(negedge clk);
      cyc     = c;
      issuing = act && (cyc >= t0 + 1) && (cyc <= t0 + w + 2);
      done    = act && (cyc == t0 + w + 3);
      if (err_at >= 0 && cyc >= err_at) begin
        exp_err = 1'b1;
      end
      run_checks();
      drive_stim();
      model_step();
      drive_mem();
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
